seg7_scan_controller: RTL
=========================

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the clock cycles each digit is shown (legal range 2 to 2^20-1).
REQ-002 CLK  input  1  system clock; the block SHALL use one clock, with all state updated on its rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 LOAD_VALID  input  1  the requester SHALL hold it high while offering a new value.
REQ-005 LOAD_DATA  input  16  four hex nibbles; nibble k SHALL be shown on digit k (digit 0 is bits [3:0]).
REQ-006 LOAD_DOTS  input  4  decimal-point enables; bit k SHALL control digit k.
REQ-007 BLANK_LZ  input  1  leading-zero blanking enable, sampled every cycle.
REQ-008 LOAD_READY  output  1  SHALL be high when a load can be accepted.
REQ-009 SEG_SELECT_OUT  output  2  index of the active digit, which drives the 7-seg decoder's select.
REQ-010 BIN_OUT  output  4  nibble for the active digit.
REQ-011 DOT_OUT  output  1  decimal point for the active digit, active-high.
REQ-012 DIGIT_EN_OUT  output  1  SHALL be 0 when the active digit is to be blanked.
REQ-013 FRAME_TICK  output  1  SHALL give a one-cycle pulse at each frame boundary.

Function
REQ-014 Divider: the counter SHALL run 0..REFRESH_DIV-1 and then wrap to 0; tick SHALL be asserted in the cycle where the count equals REFRESH_DIV-1.
REQ-015 Digit index: on each tick, the index SHALL advance 0->1->2->3->0; otherwise it SHALL hold.
REQ-016 A frame boundary SHALL be a tick while the index is 3; FRAME_TICK SHALL be registered and go high for exactly the cycle after that edge.
REQ-017 Outputs SHALL be combinational from registers only: SEG_SELECT_OUT=index, BIN_OUT=disp[index], DOT_OUT=dots[index]; there SHALL be no extra pipeline latency.
REQ-018 The load FSM SHALL have two states, SCAN (LOAD_READY=1) and PENDING (LOAD_READY=0).
REQ-019 SCAN to PENDING: when LOAD_VALID && LOAD_READY, LOAD_DATA and LOAD_DOTS SHALL be captured into the shadow register.
REQ-020 PENDING to SCAN: at a frame boundary, shadow SHALL be copied to disp/dots; the index wraps to 0 on the same edge, so digit 0 of the new frame SHALL show the new value.
REQ-021 A load accepted in the same cycle as a frame boundary SHALL go to the shadow register and SHALL commit at the next boundary, not the current one.
REQ-022 While in PENDING, LOAD_VALID SHALL be ignored; the shadow register SHALL NOT be overwritten.
REQ-023 The displayed value SHALL never change mid-frame, so there is no tearing.
REQ-024 Blanking: when BLANK_LZ=1, digit k>0 SHALL be blanked (DIGIT_EN_OUT=0) if disp nibbles k..3 are all zero.
REQ-025 Digit 0 SHALL never be blanked.
REQ-026 When BLANK_LZ=0, DIGIT_EN_OUT SHALL be 1.
REQ-027 Blanking SHALL NOT suppress DOT_OUT; DOT_OUT follows dots[index] regardless of blanking.
REQ-028 Width: the divider SHALL be wide enough for REFRESH_DIV-1 without overflow; no other arithmetic is needed.

Reset
REQ-029 When RESET=1 at an edge, the following SHALL be cleared: divider=0, index=0, disp=0, dots=0, shadow=0, and the FSM returns to SCAN.
REQ-030 Output values after reset SHALL be: SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, DIGIT_EN_OUT=1, FRAME_TICK=0, LOAD_READY=1.
REQ-031 A reset during PENDING SHALL discard the shadow value; it SHALL never be displayed.
REQ-032 Reset SHALL take priority over a load and a tick in the same cycle.

Verification (REFRESH_DIV=4, so a frame is 16 cycles)
REQ-033 Release reset, no load -> SEG_SELECT_OUT steps 0,1,2,3 every 4 cycles, BIN_OUT=0, FRAME_TICK pulses every 16 cycles.
REQ-034 Load 16'h12AF with dots 4'b0100 mid-frame -> LOAD_READY drops the next cycle; at the next boundary BIN_OUT shows F,A,2,1 on digits 0..3 and DOT_OUT=1 only on digit 2.
REQ-035 A second LOAD_VALID while PENDING with 16'hFFFF -> it is ignored; 16'h12AF is displayed; LOAD_READY rises the cycle after commit.
REQ-036 Load coincident with a boundary tick -> the value is not shown in the immediately following frame; it appears one frame later.
REQ-037 BLANK_LZ=1 with value 16'h0040 -> DIGIT_EN_OUT=1 on digits 0,1 and 0 on digits 2,3; with value 16'h0000 -> only digit 0 is enabled.
REQ-038 Assert RESET for 1 cycle while PENDING -> all outputs return to their reset values; the pending value is never displayed.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous
// double-buffered loads and optional leading-zero blanking.
module seg7_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dots,
  input  logic        blank_lz,
  output logic        load_ready,
  output logic [1:0]  seg_select_out,
  output logic [3:0]  bin_out,
  output logic        dot_out,
  output logic        digit_en_out,
  output logic        frame_tick
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

  localparam logic [0:0] SCAN    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [DW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [15:0]   disp, shadow;
  logic [3:0]    dots, shadow_dots;
  logic [0:0]    state;
  logic          tick, frame_bnd;
  logic [3:0]    nz_above;

  assign tick      = (div_cnt == DIV_MAX);
  assign frame_bnd = tick && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      idx         <= '0;
      disp        <= '0;
      dots        <= '0;
      shadow      <= '0;
      shadow_dots <= '0;
      state       <= SCAN;
      frame_tick  <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + DW'(1);
      frame_tick <= frame_bnd;
      if (tick) idx <= idx + 2'd1;
      case (state)
        SCAN: if (load_valid) begin
          shadow      <= load_data;
          shadow_dots <= load_dots;
          state       <= PENDING;
        end
        default: if (frame_bnd) begin
          // commit lands on the same edge idx wraps to 0, so a frame is never torn
          disp  <= shadow;
          dots  <= shadow_dots;
          state <= SCAN;
        end
      endcase
    end
  end

  // nz_above[k]: some nibble k..3 of the displayed value is nonzero
  for (genvar k = 0; k < 4; k++) begin : g_nz
    assign nz_above[k] = |disp[15:4*k];
  end

  assign load_ready     = (state == SCAN);
  assign seg_select_out = idx;
  assign bin_out        = disp[{idx, 2'b00} +: 4];
  assign dot_out        = dots[idx];
  assign digit_en_out   = !blank_lz || (idx == 2'd0) || nz_above[idx];

endmodule
